// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes
// (as emitted by the decoder) and the FSM state encoding.
package muldiv_pkg;

    // RV32M funct3 codes
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIN  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit for the EX stage.
// Handshake: a request is accepted on a cycle where start=1, kill=0 and the
// unit is in IDLE; busy (CALC/FIN) stalls EX, done pulses for one cycle
// when y carries the new result. Requests outside IDLE are dropped, and
// kill aborts whatever is in flight without touching y.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              kill,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] y
);

    md_state_e           state, state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          op_q;
    logic                neg_q;
    logic                spec_q;
    logic [2*DATA_W-1:0] acc;   // {hi, lo}: product, or {remainder, quotient}
    logic [DATA_W-1:0]   dvs;   // multiplicand / divisor magnitude

    logic                accept;
    logic                a_sgn, b_sgn, neg_in;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic                div_zero, ovf, special;
    logic [DATA_W-1:0]   spec_res;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_nx;
    logic [DATA_W+1:0]   div_diff;
    logic [2*DATA_W-1:0] div_nx;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo, rem, fin_res;

    assign accept = (state == MD_IDLE) && start && !kill;
    assign busy   = (state == MD_CALC) || (state == MD_FIN);
    assign done   = (state == MD_DONE) && !kill;

    // Operand preparation on accept: magnitudes, result sign, special cases
    always_comb begin
        a_sgn    = a[DATA_W-1] && (op == MD_MULH || op == MD_MULHSU ||
                                   op == MD_DIV  || op == MD_REM);
        b_sgn    = b[DATA_W-1] && (op == MD_MULH || op == MD_DIV || op == MD_REM);
        a_mag    = a_sgn ? -a : a;
        b_mag    = b_sgn ? -b : b;
        neg_in   = (op == MD_REM) ? a_sgn : (a_sgn ^ b_sgn);
        div_zero = op[2] && (b == '0);
        ovf      = (op == MD_DIV || op == MD_REM) &&
                   (a == {1'b1, {(DATA_W-1){1'b0}}}) && (b == '1);
        special  = div_zero || ovf;
        spec_res = '0;
        if (div_zero)
            spec_res = op[1] ? a : '1;
        else if (ovf)
            spec_res = op[1] ? '0 : a;
    end

    // One iteration step: shift-add multiply and restoring divide
    always_comb begin
        mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, dvs};
        mul_nx   = acc[0] ? {mul_sum, acc[DATA_W-1:1]} : {1'b0, acc[2*DATA_W-1:1]};
        div_diff = {1'b0, acc[2*DATA_W-1:DATA_W-1]} - {2'b00, dvs};
        div_nx   = div_diff[DATA_W+1] ? {acc[2*DATA_W-2:0], 1'b0}
                                      : {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    end

    // Sign fix and output-half selection used in FIN
    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = acc[DATA_W-1:0];
        rem  = acc[2*DATA_W-1:DATA_W];
        if (spec_q)
            fin_res = acc[DATA_W-1:0];
        else if (!op_q[2])
            fin_res = (op_q == MD_MUL) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
        else if (op_q[1])
            fin_res = neg_q ? -rem : rem;
        else
            fin_res = neg_q ? -quo : quo;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; kill returns to IDLE from anywhere
    always_comb begin
        state_nx = state;
        if (kill) begin
            state_nx = MD_IDLE;
        end else begin
            case (state)
                MD_IDLE: if (start) state_nx = special ? MD_FIN : MD_CALC;
                MD_CALC: if (cnt == CNT_W'(DATA_W-1)) state_nx = MD_FIN;
                MD_FIN:  state_nx = MD_DONE;
                MD_DONE: state_nx = MD_IDLE;
                default: state_nx = MD_IDLE;
            endcase
        end
    end

    // Datapath: capture on accept, iterate in CALC, write y in FIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            spec_q <= 1'b0;
            acc    <= '0;
            dvs    <= '0;
            y      <= '0;
        end else if (accept) begin
            op_q   <= op;
            neg_q  <= neg_in;
            spec_q <= special;
            dvs    <= b_mag;
            cnt    <= '0;
            acc    <= {{DATA_W{1'b0}}, special ? spec_res : a_mag};
        end else if (state == MD_CALC && !kill) begin
            acc <= op_q[2] ? div_nx : mul_nx;
            cnt <= cnt + 1'b1;
        end else if (state == MD_FIN && !kill) begin
            y <= fin_res;
        end
    end

endmodule
